mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Bus controller between the PDP-11 CPU and the behavioral 64 KB RAM. It accepts one CPU transfer at a time over a valid/ready request channel and sequences the RAM's address, write-enable, byte-write and data lines, including wait states. It returns read data or an error status on a one-cycle response pulse. Odd-address word transfers and accesses to the unpopulated I/O page are turned into bus errors instead of reaching RAM.

Parameters:
WAIT_STATES, 1, cycles the address is held on the RAM before the read sample or write strobe (range 1..15)
IO_BASE, 16'hE000, first address of the I/O page (octal 160000); addresses >= IO_BASE are non-existent
TIMEOUT, 8, cycles before a non-existent access reports a bus error (range 1..255)

Ports:
clk  in  1  system clock; all state changes on posedge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  CPU presents a transfer
req_ready  out  1  controller can accept; high only in IDLE
req_addr  in  16  byte address
req_write  in  1  1 = write (DATO/DATOB), 0 = read (DATI)
req_byte  in  1  1 = byte transfer, 0 = word transfer
req_wdata  in  16  write data; for byte writes only [7:0] is used
rsp_valid  out  1  one-cycle pulse: transfer complete
rsp_rdata  out  16  read data, valid with rsp_valid; byte reads zero-extended
rsp_err  out  2  00 ok, 01 odd-address trap, 10 bus timeout; valid with rsp_valid
mem_addr  out  16  RAM address
mem_we  out  1  RAM write enable
mem_bytew  out  1  RAM byte-write select
mem_din  out  16  RAM write data
mem_dout  in  16  RAM read data (combinational from mem_addr)

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=00; mem_addr=0, mem_we=0, mem_bytew=0, mem_din=0; counters cleared. A reset during any state aborts the transfer with no response. mem_we is low after that edge.
- States: IDLE, ACCESS, NXM, RESP.
- IDLE: a handshake (req_valid & req_ready) registers addr, write, byte and wdata.
  - Odd address with req_byte=0 -> RESP, rsp_err=01. No RAM cycle; mem_we stays 0.
  - req_addr >= IO_BASE -> NXM.
  - Otherwise -> ACCESS, wait counter = WAIT_STATES-1.
- ACCESS:
  - mem_addr = captured address, mem_bytew = captured byte flag.
  - mem_din = {wdata[7:0], wdata[7:0]} for byte writes, wdata for word writes.
  - Counter decrements each cycle. On the cycle the counter is 0:
    - write: mem_we=1 for exactly that cycle.
    - read: mem_dout is registered into rsp_rdata; byte read takes mem_dout[7:0] with [15:8]=0.
  - Next state RESP, rsp_err=00.
- NXM: timeout counter counts TIMEOUT cycles, then -> RESP with rsp_err=10 and rsp_rdata=0. mem_we is never asserted.
- RESP: rsp_valid=1 for one cycle, req_ready=0, then -> IDLE.
- rsp_rdata and rsp_err hold their values until the next response.
- Latency from the accept edge to rsp_valid high:
  - RAM access: WAIT_STATES+1 cycles.
  - Odd-address trap: 1 cycle.
  - Timeout: TIMEOUT+1 cycles.
- Back-to-back: the earliest next accept is the cycle after RESP, so the minimum issue interval is WAIT_STATES+2.
- req_valid during a busy state is ignored (req_ready=0); the CPU must hold it.
- Address 16'hDFFF byte = valid RAM access. 16'hE000 = NXM. 16'hFFFF word = odd-address trap; the odd check takes priority over NXM.
- mem_we must never be high outside ACCESS.

Decomposition:
- Package pdp11_bus_pkg holds the state enum (IDLE/ACCESS/NXM/RESP), the rsp_err codes (BUS_OK, BUS_ODD, BUS_TMO) and IO_BASE_DEFAULT.
- No sub-module: the wait counter and timeout counter share one 8-bit down-counter inside the block.

Test Plan:
- Reset, then word write 16'h1234 to 16'h0100, then word read of 16'h0100 -> mem_we high exactly 1 cycle; read rsp_rdata=16'h1234, rsp_err=00; rsp_valid 2 cycles after accept (WAIT_STATES=1).
- Word 16'hABCD at 16'h0200; byte write 8'h5A at 16'h0201; word read of 16'h0200 -> RAM word 16'h5ACD; byte read of 16'h0201 -> rsp_rdata=16'h005A.
- Word read at 16'h0203 -> rsp_err=01 one cycle after accept, mem_we never high, RAM unchanged.
- Byte read at 16'hE010 -> rsp_err=10, rsp_rdata=0, rsp_valid TIMEOUT+1=9 cycles after accept; req_ready low throughout.
- reset_n low during ACCESS of a write (WAIT_STATES=3) -> no rsp_valid, RAM word unchanged, req_ready=1 after the reset edge.
- Four back-to-back reads with req_valid held high -> accepts spaced 3 cycles apart; data returned in order.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the PDP-11 memory bus controller: FSM states,
// response status codes and the default I/O page boundary.
package pdp11_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        NXM    = 2'd2,
        RESP   = 2'd3
    } bus_state_e;

    localparam logic [1:0] BUS_OK  = 2'b00;
    localparam logic [1:0] BUS_ODD = 2'b01;
    localparam logic [1:0] BUS_TMO = 2'b10;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hE000;

    // Word transfers must be even-aligned; byte transfers may use any address.
    function automatic logic is_odd_word(input logic [15:0] addr, input logic is_byte);
        return addr[0] & ~is_byte;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Sequences one CPU transfer at a time onto the RAM with wait states,
// trapping odd word addresses and timing out accesses to the I/O page.
module mem_bus_ctrl
    import pdp11_bus_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = IO_BASE_DEFAULT,
    parameter int          TIMEOUT     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_bytew,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_STATES - 1);
    localparam logic [7:0] TMO_LOAD  = 8'(TIMEOUT - 1);

    bus_state_e  state_q;
    logic [7:0]  cnt_q;
    logic        write_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic [1:0]  rsp_err_q;
    logic [15:0] mem_addr_q;
    logic        mem_we_q;
    logic        mem_bytew_q;
    logic [15:0] mem_din_q;

    logic        odd_d;
    logic        nxm_d;
    logic [15:0] din_d;
    logic [15:0] rdata_d;

    always_comb begin
        odd_d   = is_odd_word(req_addr, req_byte);
        nxm_d   = (req_addr >= IO_BASE);
        din_d   = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
        rdata_d = mem_bytew_q ? {8'h00, mem_dout[7:0]} : mem_dout;
    end

    // One shared down-counter serves both the wait-state and timeout phases.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            write_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= BUS_OK;
            mem_addr_q  <= 16'h0000;
            mem_we_q    <= 1'b0;
            mem_bytew_q <= 1'b0;
            mem_din_q   <= 16'h0000;
        end else begin
            rsp_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        req_ready_q <= 1'b0;
                        if (odd_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= BUS_ODD;
                            rsp_rdata_q <= 16'h0000;
                        end else if (nxm_d) begin
                            state_q <= NXM;
                            cnt_q   <= TMO_LOAD;
                        end else begin
                            state_q     <= ACCESS;
                            cnt_q       <= WAIT_LOAD;
                            mem_addr_q  <= req_addr;
                            mem_bytew_q <= req_byte;
                            mem_din_q   <= din_d;
                            mem_we_q    <= req_write && (WAIT_LOAD == 8'd0);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 8'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= BUS_OK;
                        rsp_rdata_q <= write_q ? 16'h0000 : rdata_d;
                    end else begin
                        cnt_q    <= cnt_q - 8'd1;
                        mem_we_q <= write_q && (cnt_q == 8'd1);
                    end
                end
                NXM: begin
                    if (cnt_q == 8'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= BUS_TMO;
                        rsp_rdata_q <= 16'h0000;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_bytew = mem_bytew_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a WAIT_STATES=1 instance for the main
// traffic and a WAIT_STATES=3 instance for reset-abort behaviour.
module tb_mem_bus_ctrl;
    import pdp11_bus_pkg::*;

    localparam int EW = 27;  // {chk_rdata, rdata[15:0], err[1:0], latency[7:0]}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];

    // Main instance, WAIT_STATES=1
    logic        reset_n, req_valid, req_ready, req_write, req_byte;
    logic [15:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_din, mem_dout;
    logic        rsp_valid, mem_we, mem_bytew;
    logic [1:0]  rsp_err;

    mem_bus_ctrl #(.WAIT_STATES(1), .IO_BASE(16'hE000), .TIMEOUT(8)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_byte(req_byte), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_bytew(mem_bytew),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Second instance, WAIT_STATES=3
    logic        reset3_n, req_valid3, req_ready3, req_write3, req_byte3;
    logic [15:0] req_addr3, req_wdata3, rsp_rdata3, mem_addr3, mem_din3, mem_dout3;
    logic        rsp_valid3, mem_we3, mem_bytew3;
    logic [1:0]  rsp_err3;

    mem_bus_ctrl #(.WAIT_STATES(3), .IO_BASE(16'hE000), .TIMEOUT(8)) u_dut3 (
        .clk(clk), .reset_n(reset3_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
        .req_write(req_write3), .req_byte(req_byte3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_bytew(mem_bytew3),
        .mem_din(mem_din3), .mem_dout(mem_dout3)
    );

    // Behavioural RAMs: byte lane chosen by address bit 0, byte reads land in [7:0]
    logic [15:0] ram1 [0:32767] = '{default: 16'h0000};
    logic [15:0] ram3 [0:32767] = '{default: 16'h0000};
    logic [15:0] ram1_word, ram3_word;

    assign ram1_word = ram1[mem_addr[15:1]];
    assign ram3_word = ram3[mem_addr3[15:1]];
    assign mem_dout  = mem_bytew ? {8'h00, (mem_addr[0] ? ram1_word[15:8] : ram1_word[7:0])} : ram1_word;
    assign mem_dout3 = mem_bytew3 ? {8'h00, (mem_addr3[0] ? ram3_word[15:8] : ram3_word[7:0])} : ram3_word;

    int we1 = 0;
    int we3 = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            we1 <= we1 + 1;
            if (!mem_bytew)       ram1[mem_addr[15:1]]       <= mem_din;
            else if (mem_addr[0]) ram1[mem_addr[15:1]][15:8] <= mem_din[15:8];
            else                  ram1[mem_addr[15:1]][7:0]  <= mem_din[7:0];
        end
        if (mem_we3) begin
            we3 <= we3 + 1;
            if (!mem_bytew3)       ram3[mem_addr3[15:1]]       <= mem_din3;
            else if (mem_addr3[0]) ram3[mem_addr3[15:1]][15:8] <= mem_din3[15:8];
            else                   ram3[mem_addr3[15:1]][7:0]  <= mem_din3[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one request, waits for the handshake and queues the expected response.
    task automatic issue(input logic [15:0] a, input logic w, input logic b, input logic [15:0] wd,
                         input logic chk, input logic [15:0] rd, input logic [1:0] e,
                         input int lat, input logic keep, output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        @(negedge clk);
        req_addr  = a;
        req_write = w;
        req_byte  = b;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (req_ready) begin
                done = 1'b1;
                acc  = cyc + 1;
                exp_q.push_back({chk, rd, e, 8'(lat)});
                acc_q.push_back(acc);
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout addr=%h: req_ready stayed 0, expected 1", a);
            keep = 1'b0;
        end
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: every response pops the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h err=%b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                logic [EW-1:0] ex;
                int            a;
                ex = exp_q.pop_front();
                a  = acc_q.pop_front();
                check("rsp_err", {30'd0, rsp_err}, {30'd0, ex[9:8]});
                check("rsp_latency", cyc - a + 1, {24'd0, ex[7:0]});
                if (ex[26]) check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, ex[25:10]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, a0, a1, a2, a3, seen;
        reset_n = 1'b0; reset3_n = 1'b0;
        req_valid = 1'b0; req_addr = 16'h0; req_write = 1'b0; req_byte = 1'b0; req_wdata = 16'h0;
        req_valid3 = 1'b0; req_addr3 = 16'h0; req_write3 = 1'b0; req_byte3 = 1'b0; req_wdata3 = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp", {rsp_rdata, rsp_err}, 18'h0);
        check("rst_mem", {mem_addr, mem_we, mem_bytew, mem_din}, 34'h0);
        reset_n = 1'b1; reset3_n = 1'b1;

        // Word write then read back
        w0 = we1;
        issue(16'h0100, 1, 0, 16'h1234, 0, 16'h0, BUS_OK, 2, 0, a0);
        drain();
        check("we_pulses_write", we1 - w0, 1);
        check("ram_0100", ram1[16'h0080], 16'h1234);
        issue(16'h0100, 0, 0, 16'h0, 1, 16'h1234, BUS_OK, 2, 0, a0);
        drain();

        // Byte lane merge
        issue(16'h0200, 1, 0, 16'hABCD, 0, 16'h0, BUS_OK, 2, 0, a0);
        issue(16'h0201, 1, 1, 16'hFF5A, 0, 16'h0, BUS_OK, 2, 0, a0);
        issue(16'h0200, 0, 0, 16'h0, 1, 16'h5ACD, BUS_OK, 2, 0, a0);
        issue(16'h0201, 0, 1, 16'h0, 1, 16'h005A, BUS_OK, 2, 0, a0);
        issue(16'h0200, 0, 1, 16'h0, 1, 16'h00CD, BUS_OK, 2, 0, a0);
        drain();

        // Odd-address word traps
        w0 = we1;
        issue(16'h0203, 0, 0, 16'h0, 0, 16'h0, BUS_ODD, 1, 0, a0);
        issue(16'h0203, 1, 0, 16'h9999, 0, 16'h0, BUS_ODD, 1, 0, a0);
        drain();
        check("we_pulses_odd", we1 - w0, 0);
        check("ram_0202", ram1[16'h0101], 16'h0000);

        // Non-existent I/O page read
        w0 = we1;
        issue(16'hE010, 0, 1, 16'h0, 1, 16'h0000, BUS_TMO, 9, 0, a0);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (req_ready) seen++;
        end
        check("nxm_ready_low", seen, 0);
        drain();
        check("we_pulses_nxm", we1 - w0, 0);

        // Address boundaries
        issue(16'hDFFF, 1, 1, 16'h3377, 0, 16'h0, BUS_OK, 2, 0, a0);
        issue(16'hDFFF, 0, 1, 16'h0, 1, 16'h0077, BUS_OK, 2, 0, a0);
        issue(16'hE000, 0, 0, 16'h0, 1, 16'h0000, BUS_TMO, 9, 0, a0);
        issue(16'hFFFF, 0, 0, 16'h0, 0, 16'h0, BUS_ODD, 1, 0, a0);
        drain();
        check("ram_dffe", ram1[16'h6FFF], 16'h7700);

        // Back-to-back reads with req_valid held
        issue(16'h0100, 0, 0, 16'h0, 1, 16'h1234, BUS_OK, 2, 1, a0);
        issue(16'h0200, 0, 0, 16'h0, 1, 16'h5ACD, BUS_OK, 2, 1, a1);
        issue(16'h0201, 0, 1, 16'h0, 1, 16'h005A, BUS_OK, 2, 1, a2);
        issue(16'hDFFE, 0, 0, 16'h0, 1, 16'h7700, BUS_OK, 2, 0, a3);
        drain();
        check("b2b_gap0", a1 - a0, 3);
        check("b2b_gap1", a2 - a1, 3);
        check("b2b_gap2", a3 - a2, 3);

        // Reset during a WAIT_STATES=3 write aborts it
        @(negedge clk);
        req_addr3 = 16'h0300; req_write3 = 1'b1; req_byte3 = 1'b0; req_wdata3 = 16'hBEEF;
        req_valid3 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !req_ready3; i++) @(negedge clk);
        check("dut3_ready_before", req_ready3, 1);
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        @(negedge clk);
        reset3_n = 1'b0;
        @(negedge clk);
        check("dut3_ready_after_rst", req_ready3, 1);
        check("dut3_we_after_rst", mem_we3, 0);
        reset3_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid3) seen++;
        end
        check("dut3_no_rsp", seen, 0);
        check("dut3_we_pulses", we3, 0);
        check("dut3_ram_0300", ram3[16'h0180], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
